led_counter: RTL and testbench
==============================

LED_COUNTER -- requirements
Module: led_counter

Interface
REQ-001 Parameter WIDTH, default 8, LED/pattern width; legal range 2..32.
REQ-002 Parameter DIV, default 12_000_000, prescaler period in clk cycles per step; legal range >= 1.
REQ-003 Parameter INIT, default 'h55 (WIDTH bits), pattern value after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  high: prescaler runs and pattern steps; low: all state frozen.
REQ-007 mode  input  2  step operation: 0 UP, 1 DOWN, 2 ROTL, 3 ROTR.
REQ-008 load  input  1  one-cycle request to overwrite pattern with load_value.
REQ-009 load_value  input  WIDTH  value written on load.
REQ-010 leds  output  WIDTH  current pattern, driven directly from the pattern register.
REQ-011 tick  output  1  one-cycle pulse, high in the first cycle a stepped pattern is visible on leds.
REQ-012 wrap  output  1  one-cycle pulse, high with tick when an UP/DOWN step wraps.

Function
REQ-013 Prescaler div_cnt, width clog2(DIV) (min 1): while en=1, increments each cycle; at DIV-1 it returns to 0 and asserts internal step for that cycle.
REQ-014 DIV=1: step asserted on every enabled cycle.
REQ-015 On the edge where step=1, pattern updates per mode sampled in that same cycle: UP +1 mod 2^WIDTH; DOWN -1 mod 2^WIDTH; ROTL {p[W-2:0],p[W-1]}; ROTR {p[0],p[W-1:1]}.
REQ-016 tick is registered: tick=1 exactly in the cycle after the stepping edge (coincident with the new leds value), otherwise 0.
REQ-017 wrap=1 together with tick only when UP stepped from all-ones to 0 or DOWN stepped from 0 to all-ones; always 0 in ROTL/ROTR.
REQ-018 load=1 (regardless of en): next cycle pattern=load_value, div_cnt=0, tick=0, wrap=0; load overrides a simultaneous step.
REQ-019 en=0: div_cnt, pattern hold; tick and wrap go 0 on the next edge.
REQ-020 Mode change mid-period does not reset div_cnt; it affects only the next step.
REQ-021 Rotating an all-zero or all-ones pattern yields the same value; tick still pulses.

Reset
REQ-022 rst=1 at an edge: pattern=INIT, div_cnt=0, tick=0, wrap=0; rst overrides load, en and step.
REQ-023 Reset mid-period discards the partial prescaler count; first step after release occurs DIV enabled cycles later.
REQ-024 No output is undefined after the first reset edge; leds=INIT ('h55 default) from the cycle after reset.

Structure
REQ-025 Shared package led_pkg holds the 2-bit mode type and constants MODE_UP=0, MODE_DOWN=1, MODE_ROTL=2, MODE_ROTR=3.
REQ-026 Prescaler is a sub-module tick_gen (parameter DIV; ports clk, rst, en, clr, step); clr driven by load.
REQ-027 Pattern register, step logic, tick/wrap registers live in led_counter; no latches, no derived clocks.

Verification (WIDTH=8, DIV=4 unless stated)
REQ-028 Reset, en=1, mode=UP: leds 0x55 -> 0x56 after 4 cycles, tick high exactly that cycle, repeats every 4 cycles.
REQ-029 load 0xFF, mode=UP, en=1: 4 cycles later leds=0x00 with tick=1 and wrap=1; then mode=DOWN: next step leds=0xFF, wrap=1.
REQ-030 load 0x81, mode=ROTL: steps give 0x03, 0x06; mode=ROTR from 0x01 gives 0x80; wrap stays 0.
REQ-031 en dropped for 10 cycles after 2 prescaler counts: leds unchanged, tick=0; after en=1 step occurs 2 cycles later.
REQ-032 load=1 on the step cycle with load_value 0x3C: leds=0x3C, no tick; next step 4 cycles later.
REQ-033 DIV=1, rst asserted mid-run with load=1: leds=0x55, tick=0 next cycle; after release leds increments every cycle.

Source files
------------

// File: rtl/led_pkg.sv
// led_pkg -- shared definitions for the LED pattern counter.
//   mode_t    : 2-bit step operation applied when the prescaler fires
//   cnt_width : width of a prescaler counter for a given period (minimum 1)
package led_pkg;

    typedef enum logic [1:0] {
        MODE_UP   = 2'd0,
        MODE_DOWN = 2'd1,
        MODE_ROTL = 2'd2,
        MODE_ROTR = 2'd3
    } mode_t;

    // Width needed to count 0..div-1; a period of 1 still gets one bit so
    // the counter register is never zero-width.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage : led_pkg

// File: rtl/tick_gen.sv
// tick_gen -- free-running prescaler that produces a one-cycle step strobe.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears the count
//   en   : count enable; when low the count holds and step stays low
//   clr  : synchronous clear of the count (used when the pattern is loaded)
//   step : high for the enabled cycle in which the count sits at DIV-1
module tick_gen
    import led_pkg::*;
#(
    parameter int DIV = 12_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int CNT_W = cnt_width(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + CNT_W'(1);
        end
    end

    // With DIV=1 the count is pinned at 0 == LAST, so every enabled cycle steps.
    assign step = en && (div_cnt == LAST);

endmodule : tick_gen

// File: rtl/led_counter.sv
// led_counter -- LED pattern register that steps once per prescaler period.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (pattern <= INIT)
//   en         : run enable for prescaler and pattern stepping
//   mode       : step operation (led_pkg::mode_t): UP, DOWN, ROTL, ROTR
//   load       : one-cycle request to overwrite the pattern with load_value
//   load_value : value written on load
//   leds       : current pattern, straight from the pattern register
//   tick       : one-cycle pulse in the first cycle a stepped pattern is on leds
//   wrap       : pulses with tick when an UP/DOWN step wraps around
//
// Output handshake: tick acts as a valid strobe with no ready; leds and wrap
// are meaningful as a step result only in the single cycle tick=1, and the
// consumer must take them in that cycle. Load and reset never raise tick.
module led_counter
    import led_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               DIV   = 12_000_000,
    parameter logic [WIDTH-1:0] INIT  = WIDTH'('h55)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] leds,
    output logic             tick,
    output logic             wrap
);

    logic             step;
    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] next_pattern;
    logic             next_wrap;

    // A load restarts the prescaler period so the next step is a full DIV
    // enabled cycles after the loaded value appears.
    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .step (step)
    );

    always_comb begin
        next_pattern = pattern;
        next_wrap    = 1'b0;
        case (mode_t'(mode))
            MODE_UP: begin
                next_pattern = pattern + WIDTH'(1);
                next_wrap    = (pattern == '1);
            end
            MODE_DOWN: begin
                next_pattern = pattern - WIDTH'(1);
                next_wrap    = (pattern == '0);
            end
            MODE_ROTL: next_pattern = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
            MODE_ROTR: next_pattern = {pattern[0], pattern[WIDTH-1:1]};
        endcase
    end

    // Priority: reset, then load, then step. Any cycle without a step
    // drops tick/wrap, which also covers en=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern <= INIT;
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end else if (load) begin
            pattern <= load_value;
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end else if (step) begin
            pattern <= next_pattern;
            tick    <= 1'b1;
            wrap    <= next_wrap;
        end else begin
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end
    end

    assign leds = pattern;

endmodule : led_counter

// File: tb/tb_led_counter.sv
// tb_led_counter -- scoreboard bench for led_counter. Two instances share
// the same stimulus: one with DIV=4, one with DIV=1, both WIDTH=8.
module tb_led_counter;
    import led_pkg::*;

    localparam int W  = 8;
    localparam int EW = W + 2;          // {tick, wrap, leds}
    localparam int INIT_VAL = 'h55;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic [W-1:0] leds4, leds1;
    logic         tick4, tick1, wrap4, wrap1;

    led_counter #(.WIDTH(W), .DIV(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
        .load_value(load_value), .leds(leds4), .tick(tick4), .wrap(wrap4)
    );

    led_counter #(.WIDTH(W), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
        .load_value(load_value), .leds(leds1), .tick(tick1), .wrap(wrap1)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp4_q[$];
    logic [EW-1:0] exp1_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: pattern as an integer and the number of enabled
    // cycles since the last reset/load/step.
    int pat4 = 0, ph4 = 0;
    int pat1 = 0, ph1 = 0;

    task automatic model(input int div, inout int pat, inout int ph,
                         input logic r, input logic l, input logic e,
                         input logic [1:0] m, input logic [W-1:0] lv,
                         output logic [EW-1:0] exp_v);
        logic t, w;
        t = 1'b0;
        w = 1'b0;
        if (r) begin
            pat = INIT_VAL;
            ph  = 0;
        end else if (l) begin
            pat = int'(lv);
            ph  = 0;
        end else if (e) begin
            ph = ph + 1;
            if (ph == div) begin
                ph = 0;
                t  = 1'b1;
                case (m)
                    2'd0: begin w = (pat == 255); pat = (pat + 1) % 256; end
                    2'd1: begin w = (pat == 0);   pat = (pat + 255) % 256; end
                    2'd2: pat = ((pat * 2) % 256) + (pat / 128);
                    default: pat = (pat / 2) + ((pat % 2) * 128);
                endcase
            end
        end
        exp_v = {t, w, W'(pat)};
    endtask

    // Driver: one call = one clock cycle of inputs, applied on the falling
    // edge; the predicted result of the following rising edge is queued.
    task automatic drive(input logic r, input logic l, input logic e,
                         input logic [1:0] m, input logic [W-1:0] lv);
        logic [EW-1:0] x;
        @(negedge clk);
        rst = r; load = l; en = e; mode = m; load_value = lv;
        model(4, pat4, ph4, r, l, e, m, lv, x);
        exp4_q.push_back(x);
        model(1, pat1, ph1, r, l, e, m, lv, x);
        exp1_q.push_back(x);
    endtask

    task automatic run(input int n, input logic [1:0] m);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, m, '0);
    endtask

    task automatic do_load(input logic [W-1:0] v);
        drive(1'b0, 1'b1, 1'b0, MODE_UP, v);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        logic [EW-1:0] e, g;
        forever begin
            @(posedge clk);
            #1;
            if (exp4_q.size() > 0) begin
                e = exp4_q.pop_front();
                g = {tick4, wrap4, leds4};
                n_tests++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL div4 t=%0t got leds=%h tick=%b wrap=%b exp leds=%h tick=%b wrap=%b",
                             $time, g[W-1:0], g[W+1], g[W], e[W-1:0], e[W+1], e[W]);
                end
            end
            if (exp1_q.size() > 0) begin
                e = exp1_q.pop_front();
                g = {tick1, wrap1, leds1};
                n_tests++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL div1 t=%0t got leds=%h tick=%b wrap=%b exp leds=%h tick=%b wrap=%b",
                             $time, g[W-1:0], g[W+1], g[W], e[W-1:0], e[W+1], e[W]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic r, l, e;
        logic [1:0] m;
        // reset
        drive(1'b1, 1'b0, 1'b0, MODE_UP, '0);
        drive(1'b1, 1'b1, 1'b1, MODE_UP, 8'hAA);   // reset beats load/en
        // counting up from INIT, step every 4 cycles
        run(12, MODE_UP);
        // wrap up then wrap down
        do_load(8'hFF);
        run(4, MODE_UP);
        run(4, MODE_DOWN);
        // rotations, including mode change mid-period
        do_load(8'h81);
        run(8, MODE_ROTL);
        do_load(8'h01);
        run(4, MODE_ROTR);
        run(2, MODE_UP);
        run(2, MODE_ROTL);
        // rotating all-zero / all-ones still ticks
        do_load(8'h00);
        run(4, MODE_ROTL);
        do_load(8'hFF);
        run(4, MODE_ROTR);
        // enable dropped mid-period
        do_load(8'h10);
        run(2, MODE_UP);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0, MODE_UP, '0);
        run(4, MODE_UP);
        // load coincident with the step cycle
        do_load(8'h00);
        run(3, MODE_UP);
        drive(1'b0, 1'b1, 1'b1, MODE_UP, 8'h3C);
        run(5, MODE_UP);
        // reset with load mid-run, then release
        run(3, MODE_UP);
        drive(1'b1, 1'b1, 1'b1, MODE_UP, 8'h99);
        run(6, MODE_UP);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 99) < 2);
            l = ($urandom_range(0, 99) < 5);
            e = ($urandom_range(0, 99) < 85);
            m = 2'($urandom_range(0, 3));
            drive(r, l, e, m, W'($urandom_range(0, 255)));
        end
        // drain
        @(posedge clk);
        #3;
        n_tests++;
        if (exp4_q.size() != 0 || exp1_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got pending=%0d/%0d exp pending=0/0",
                     exp4_q.size(), exp1_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_led_counter
